// File: rtl/contador_mod_updown.sv
// contador_mod_updown
// Modulo up/down counter with an enable-driven prescaler, synchronous
// clear, clamped parallel load, wrap or saturate behaviour at the terminal
// value, and a registered ripple-carry pulse for cascading counters.

module contador_mod_updown #(
    parameter int N        = 4,
    parameter int MOD      = 16,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_dn,
    input  logic         sat_mode,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         rco,
    output logic         at_term
);

    // A one-bit prescaler is kept even when PRESCALE is 1; it simply stays at 0.
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]  MAX_VAL  = N'(MOD - 1);
    localparam logic [N-1:0]  ONE_N    = N'(1);
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE_P    = PW'(1);
    // The modulus may equal 2**N, so the load comparison is done one bit wider.
    localparam logic [N:0]    MOD_EXT  = (N + 1)'(MOD);

    logic [PW-1:0] psc;
    logic [PW-1:0] psc_next;
    logic [N-1:0]  count_next;
    logic [N-1:0]  terminal;
    logic [N-1:0]  load_clamped;
    logic          rco_next;
    logic          step;

    always_comb begin
        terminal     = up_dn ? MAX_VAL : '0;
        at_term      = (count == terminal);
        step         = en && (psc == PSC_LAST);
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end

    // Next-state selection in priority order clr > load > step > hold.
    // Incrementing/decrementing never leaves the legal count range because the terminal
    // value is handled separately by wrapping or holding.
    always_comb begin
        count_next = count;
        psc_next   = psc;
        rco_next   = 1'b0;
        if (clr) begin
            count_next = '0;
            psc_next   = '0;
        end else if (load) begin
            count_next = load_clamped;
            psc_next   = '0;
        end else if (en) begin
            if (step) begin
                psc_next = '0;
                if (at_term) begin
                    rco_next = 1'b1;
                    if (!sat_mode) begin
                        count_next = up_dn ? '0 : MAX_VAL;
                    end
                end else begin
                    count_next = up_dn ? (count + ONE_N) : (count - ONE_N);
                end
            end else begin
                psc_next = psc + ONE_P;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            psc   <= '0;
            rco   <= 1'b0;
        end else begin
            count <= count_next;
            psc   <= psc_next;
            rco   <= rco_next;
        end
    end

endmodule

// File: tb/tb_contador_mod_updown.sv
// tb_contador_mod_updown
// Self-checking bench for contador_mod_updown. Two instances share all control
// inputs: dut_a (N=4, MOD=10, PRESCALE=3) and dut_b (N=2, MOD=4, PRESCALE=1).
// A behavioural model kept in integers predicts count, rco and at_term.

module tb_contador_mod_updown;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       sat_mode;
    logic       clr;
    logic       load;
    logic [3:0] load_val_a;
    logic [1:0] load_val_b;
    logic [3:0] count_a;
    logic [1:0] count_b;
    logic       rco_a;
    logic       rco_b;
    logic       term_a;
    logic       term_b;

    int errors = 0;
    int checks = 0;

    int m_count[2];
    int m_psc[2];
    bit m_rco[2];

    contador_mod_updown #(.N(4), .MOD(10), .PRESCALE(3)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val_a),
        .count    (count_a),
        .rco      (rco_a),
        .at_term  (term_a)
    );

    contador_mod_updown #(.N(2), .MOD(4), .PRESCALE(1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val_b),
        .count    (count_b),
        .rco      (rco_b),
        .at_term  (term_b)
    );

    always #5 clk = ~clk;

    function automatic int mod_of(int i);
        return (i == 0) ? 10 : 4;
    endfunction

    function automatic int psc_of(int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_psc[i]   = 0;
            m_rco[i]   = 1'b0;
        end
    endfunction

    // Predicts the state after the coming rising edge from the current inputs.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            int md;
            int lv;
            int term;
            md   = mod_of(i);
            lv   = (i == 0) ? int'(load_val_a) : int'(load_val_b);
            term = up_dn ? md - 1 : 0;
            m_rco[i] = 1'b0;
            if (clr) begin
                m_count[i] = 0;
                m_psc[i]   = 0;
            end else if (load) begin
                m_count[i] = (lv >= md) ? md - 1 : lv;
                m_psc[i]   = 0;
            end else if (en) begin
                m_psc[i] = m_psc[i] + 1;
                if (m_psc[i] == psc_of(i)) begin
                    m_psc[i] = 0;
                    if (m_count[i] == term) m_rco[i] = 1'b1;
                    if (!(m_count[i] == term && sat_mode))
                        m_count[i] = (m_count[i] + (up_dn ? 1 : md - 1)) % md;
                end
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; up_dn = 1'b0; sat_mode = 1'b0;
        clr = 1'b0; load = 1'b0; load_val_a = '0; load_val_b = '0;
        model_reset();
        #12;
        checks++;
        if (count_a !== 4'd0) begin errors++; $display("[TB] FAIL reset_count_a: got %0d expected 0", count_a); end
        checks++;
        if (count_b !== 2'd0) begin errors++; $display("[TB] FAIL reset_count_b: got %0d expected 0", count_b); end
        checks++;
        if (rco_a !== 1'b0 || rco_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_rco: got %b%b expected 00", rco_a, rco_b); end
        checks++;
        if (term_a !== 1'b1 || term_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_at_term_down: got %b%b expected 11", term_a, term_b); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Wrap counting up on the 2-bit, modulo-4 instance.
    task automatic test_wrap_up();
        int exp_seq[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
        en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (count_b !== 2'(exp_seq[i])) begin errors++; $display("[TB] FAIL wrap_up_count step %0d: got %0d expected %0d", i, count_b, exp_seq[i]); end
            checks++;
            if (rco_b !== (exp_seq[i] == 0)) begin errors++; $display("[TB] FAIL wrap_up_rco step %0d: got %b expected %b", i, rco_b, exp_seq[i] == 0); end
            checks++;
            if (term_b !== (exp_seq[i] == 3)) begin errors++; $display("[TB] FAIL wrap_up_at_term step %0d: got %b expected %b", i, term_b, exp_seq[i] == 3); end
            checks++;
            if (count_a !== 4'(m_count[0])) begin errors++; $display("[TB] FAIL wrap_up_count_a step %0d: got %0d expected %0d", i, count_a, m_count[0]); end
        end
    endtask

    // Down-counting wrap on MOD=10, then saturation at 0 with repeated rco.
    task automatic test_down_sat();
        int pulses;
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b0; sat_mode = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (count_a !== 4'(m_count[0])) begin errors++; $display("[TB] FAIL down_count edge %0d: got %0d expected %0d", i, count_a, m_count[0]); end
            checks++;
            if (rco_a !== m_rco[0]) begin errors++; $display("[TB] FAIL down_rco edge %0d: got %b expected %b", i, rco_a, m_rco[0]); end
            if (i == 2) begin
                checks++;
                if (count_a !== 4'd9 || rco_a !== 1'b1) begin errors++; $display("[TB] FAIL down_first_wrap: got count %0d rco %b expected count 9 rco 1", count_a, rco_a); end
            end
        end
        sat_mode = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rco_a === 1'b1) pulses++;
            checks++;
            if (count_a !== 4'd0 || term_a !== 1'b1) begin errors++; $display("[TB] FAIL sat_hold edge %0d: got count %0d at_term %b expected count 0 at_term 1", i, count_a, term_a); end
            checks++;
            if (rco_a !== m_rco[0]) begin errors++; $display("[TB] FAIL sat_rco edge %0d: got %b expected %b", i, rco_a, m_rco[0]); end
        end
        checks++;
        if (pulses != 4) begin errors++; $display("[TB] FAIL sat_pulse_count: got %0d expected 4", pulses); end
    endtask

    // Prescaler pacing and a two-cycle enable gap mid-prescale.
    task automatic test_prescale_gap();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (count_a !== 4'd1 && n < 10);
        checks++;
        if (n != 3) begin errors++; $display("[TB] FAIL prescale_period: got %0d edges expected 3", n); end
        n = 0;
        do begin
            en = !(n == 1 || n == 2);
            tick();
            n++;
        end while (count_a !== 4'd2 && n < 12);
        en = 1'b1;
        checks++;
        if (n != 5) begin errors++; $display("[TB] FAIL prescale_gap_delay: got %0d edges expected 5", n); end
    endtask

    // Load clamping and clr taking priority over load on the same edge.
    task automatic test_load_clr();
        int n;
        en = 1'b0; load = 1'b1; load_val_a = 4'd12; load_val_b = 2'd3;
        tick();
        load = 1'b0;
        checks++;
        if (count_a !== 4'd9) begin errors++; $display("[TB] FAIL load_clamp_a: got %0d expected 9", count_a); end
        checks++;
        if (count_b !== 2'd3) begin errors++; $display("[TB] FAIL load_b: got %0d expected 3", count_b); end
        en = 1'b1; up_dn = 1'b1;
        tick();
        clr = 1'b1; load = 1'b1; load_val_a = 4'd5;
        tick();
        clr = 1'b0; load = 1'b0;
        checks++;
        if (count_a !== 4'd0 || count_b !== 2'd0) begin errors++; $display("[TB] FAIL clr_over_load: got %0d/%0d expected 0/0", count_a, count_b); end
        n = 0;
        do begin
            tick();
            n++;
        end while (count_a === 4'd0 && n < 10);
        checks++;
        if (n != 3 || count_a !== 4'd1) begin errors++; $display("[TB] FAIL clr_psc_zero: got %0d edges count %0d expected 3 edges count 1", n, count_a); end
    endtask

    // Asynchronous reset between edges while mid-prescale.
    task automatic test_async_reset();
        en = 1'b0; load = 1'b1; load_val_a = 4'd7; load_val_b = 2'd2;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++;
        if (count_a !== 4'd7) begin errors++; $display("[TB] FAIL async_setup: got %0d expected 7", count_a); end
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count_a !== 4'd0 || rco_a !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_a: got count %0d rco %b expected 0 0", count_a, rco_a); end
        checks++;
        if (count_b !== 2'd0 || rco_b !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_b: got count %0d rco %b expected 0 0", count_b, rco_b); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (count_a !== 4'd0) begin errors++; $display("[TB] FAIL async_no_partial: got %0d expected 0", count_a); end
        tick();
        checks++;
        if (count_a !== 4'd1) begin errors++; $display("[TB] FAIL async_first_step: got %0d expected 1", count_a); end
    endtask

    // Consecutive terminal steps give consecutive rco pulses.
    task automatic test_back_to_back();
        en = 1'b0; load = 1'b1; load_val_b = 2'd3; load_val_a = 4'd0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count_b !== 2'd3 || rco_b !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sat edge %0d: got count %0d rco %b expected 3 1", i, count_b, rco_b); end
        end
        sat_mode = 1'b0;
        tick();
        checks++;
        if (count_b !== 2'd0 || rco_b !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wrap: got count %0d rco %b expected 0 1", count_b, rco_b); end
        tick();
        checks++;
        if (count_b !== 2'd1 || rco_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_after: got count %0d rco %b expected 1 0", count_b, rco_b); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            en         = ($urandom_range(3) != 0);
            up_dn      = $urandom_range(1);
            sat_mode   = $urandom_range(1);
            clr        = ($urandom_range(31) == 0);
            load       = ($urandom_range(15) == 0);
            load_val_a = 4'($urandom_range(15));
            load_val_b = 2'($urandom_range(3));
            tick();
            if ($urandom_range(499) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                @(negedge clk);
                reset = 1'b1;
            end
            checks++;
            if (count_a !== 4'(m_count[0])) begin errors++; $display("[TB] FAIL rand_count_a cycle %0d: got %0d expected %0d", i, count_a, m_count[0]); end
            checks++;
            if (count_b !== 2'(m_count[1])) begin errors++; $display("[TB] FAIL rand_count_b cycle %0d: got %0d expected %0d", i, count_b, m_count[1]); end
            checks++;
            if (rco_a !== m_rco[0] || rco_b !== m_rco[1]) begin errors++; $display("[TB] FAIL rand_rco cycle %0d: got %b%b expected %b%b", i, rco_a, rco_b, m_rco[0], m_rco[1]); end
            checks++;
            if (term_a !== (m_count[0] == (up_dn ? 9 : 0))) begin errors++; $display("[TB] FAIL rand_at_term_a cycle %0d: got %b expected %b", i, term_a, m_count[0] == (up_dn ? 9 : 0)); end
            checks++;
            if (term_b !== (m_count[1] == (up_dn ? 3 : 0))) begin errors++; $display("[TB] FAIL rand_at_term_b cycle %0d: got %b expected %b", i, term_b, m_count[1] == (up_dn ? 3 : 0)); end
            checks++;
            if (!(count_a < 4'd10)) begin errors++; $display("[TB] FAIL rand_range_a cycle %0d: got %0d expected below 10", i, count_a); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_sat();
        test_prescale_gap();
        test_load_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
